if_stage_fetch: RTL and testbench
=================================

Name: if_stage_fetch

Overview:
- Instruction-fetch stage of the PipeLineMips 5-stage core. It sits between the instruction memory and the decode stage.
- Owns the program counter and next-PC selection: sequential, branch redirect, jump redirect.
- Drives the instruction-memory read address and registers the fetched word into the IF/ID pipeline register.
- Honours stall and flush requests from the hazard/branch logic.
- Exposes pc_if and instr_if for simulation monitoring.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset; must be word-aligned.
- NOP_INSTR, 32'h0000_0000, instruction word inserted into IF/ID as a bubble (sll $0,$0,0).

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-low reset (0 = reset, sampled on rising clk)
- stall  in  1  hold PC and IF/ID contents (load-use hazard)
- flush  in  1  squash the instruction currently in IF; IF/ID becomes a bubble
- branch_taken  in  1  taken branch resolved downstream; redirect PC
- branch_target  in  32  branch destination address
- jump  in  1  jump decoded in ID; redirect PC
- jump_target  in  32  jump destination address
- imem_addr  out  32  instruction-memory read address (= PC)
- imem_rdata  in  32  instruction word; combinational read of imem_addr
- pc_if  out  32  current PC (IF stage)
- instr_if  out  32  imem_rdata passed through (IF stage)
- pc_plus4_id  out  32  IF/ID register: PC+4 of the decoded instruction
- instr_id  out  32  IF/ID register: instruction word
- valid_id  out  1  IF/ID holds a real instruction (0 = bubble)
- fetch_count  out  32  number of instructions accepted into IF/ID since reset

Behaviour:
- Reset (rst=0 at posedge):
  - PC=RESET_PC.
  - instr_id=NOP_INSTR, pc_plus4_id=0, valid_id=0, fetch_count=0.
  - Reset overrides every other input; a reset asserted mid-operation discards all in-flight state on that edge.
- Combinational outputs: imem_addr=pc_if=PC and instr_if=imem_rdata, with no added latency.
- Next-PC priority at each posedge (rst=1):
  - 1. branch_taken: PC <= {branch_target[31:2],2'b00}.
  - 2. jump: PC <= {jump_target[31:2],2'b00}.
  - 3. stall: PC holds.
  - 4. Otherwise: PC <= PC+4. This wraps modulo 2^32, so 32'hFFFF_FFFC goes to 0.
  - When branch_taken and jump are both high, branch wins, because the branch is the older instruction.
  - A redirect overrides stall.
- IF/ID update at each posedge (rst=1):
  - flush=1 or branch_taken=1: load a bubble (instr_id=NOP_INSTR, pc_plus4_id=0, valid_id=0). This takes precedence over stall.
  - Else stall=1: hold all IF/ID fields.
  - Else: instr_id<=imem_rdata, pc_plus4_id<=PC+4, valid_id<=1, fetch_count<=fetch_count+1.
- A jump does not itself bubble IF/ID. The hazard logic asserts flush alongside jump when the delay slot must be squashed.
- Latency: the word at address A appears on instr_id one clock after PC=A is presented, provided there is no stall or flush.
- fetch_count increments only on a non-stalled, non-flushed load. It wraps from 32'hFFFF_FFFF to 0.
- Misaligned RESET_PC is illegal. Redirect targets are silently aligned as above.
- No internal state besides PC, the IF/ID fields and fetch_count.

Test Plan:
- Reset then run:
  - Stimulus: rst=0 for 2 clocks, then rst=1; imem[k]=32'h1000_0000+k.
  - Required: in the first cycle after release, pc_if=0 and instr_if=32'h1000_0000.
  - Required: at the next edge, instr_id=32'h1000_0000, pc_plus4_id=4, valid_id=1.
  - Required: after 4 clocks, pc_if=0x10 and fetch_count=4.
- Stall:
  - Stimulus: with PC=0x8, assert stall for 2 clocks.
  - Required: pc_if stays 0x8 and instr_id/pc_plus4_id are unchanged.
  - Required: fetch_count does not increment.
  - Required: after stall deasserts, PC resumes at 0xC.
- Branch during stall:
  - Stimulus: PC=0x14, stall=1, branch_taken=1, branch_target=0x41.
  - Required: at the next edge, PC=0x40, valid_id=0, instr_id=0.
  - Required: one clock later, instr_id=imem[0x40>>2].
- Jump with and without flush:
  - Stimulus: jump=1, jump_target=0x100, flush=0.
  - Required: PC=0x100 and IF/ID loads the sequential word (valid_id=1).
  - Stimulus: repeat with flush=1.
  - Required: PC=0x100, valid_id=0.
- Simultaneous branch and jump:
  - Stimulus: branch_target=0x200, jump_target=0x300, both asserted.
  - Required: PC=0x200 and the IF/ID register holds a bubble.
- Wrap and reset mid-run:
  - Stimulus: force PC=0xFFFF_FFFC via branch, then run one clock.
  - Required: PC=0.
  - Stimulus: assert rst=0 for one edge while stall=1 and branch_taken=1.
  - Required: PC=RESET_PC, valid_id=0, fetch_count=0.

Source files
------------

// File: rtl/if_stage_fetch.sv
// Instruction-fetch stage: owns the PC, selects the next PC (branch/jump/sequential)
// and registers the fetched word into the IF/ID pipeline register.
module if_stage_fetch #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        flush,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [31:0] jump_target,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc_if,
  output logic [31:0] instr_if,
  output logic [31:0] pc_plus4_id,
  output logic [31:0] instr_id,
  output logic        valid_id,
  output logic [31:0] fetch_count
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_id_q, instr_id_d;
  logic [31:0] pc_plus4_id_q, pc_plus4_id_d;
  logic        valid_id_q, valid_id_d;
  logic [31:0] fetch_count_q, fetch_count_d;
  logic [31:0] pc_plus4;

  // Redirect targets are forced to word alignment, so their low bits are dropped.
  logic unused_target_bits;
  assign unused_target_bits = ^{branch_target[1:0], jump_target[1:0]};

  assign pc_plus4 = pc_q + 32'd4;

  // Next PC: the branch is the older instruction, so it beats the jump; any redirect beats stall.
  always_comb begin
    pc_d = pc_plus4;
    if (branch_taken) begin
      pc_d = {branch_target[31:2], 2'b00};
    end else if (jump) begin
      pc_d = {jump_target[31:2], 2'b00};
    end else if (stall) begin
      pc_d = pc_q;
    end
  end

  // IF/ID: a taken branch squashes the word in IF just like an explicit flush.
  always_comb begin
    instr_id_d    = instr_id_q;
    pc_plus4_id_d = pc_plus4_id_q;
    valid_id_d    = valid_id_q;
    fetch_count_d = fetch_count_q;
    if (flush || branch_taken) begin
      instr_id_d    = NOP_INSTR;
      pc_plus4_id_d = 32'd0;
      valid_id_d    = 1'b0;
    end else if (!stall) begin
      instr_id_d    = imem_rdata;
      pc_plus4_id_d = pc_plus4;
      valid_id_d    = 1'b1;
      fetch_count_d = fetch_count_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      pc_q          <= RESET_PC;
      instr_id_q    <= NOP_INSTR;
      pc_plus4_id_q <= 32'd0;
      valid_id_q    <= 1'b0;
      fetch_count_q <= 32'd0;
    end else begin
      pc_q          <= pc_d;
      instr_id_q    <= instr_id_d;
      pc_plus4_id_q <= pc_plus4_id_d;
      valid_id_q    <= valid_id_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  assign imem_addr   = pc_q;
  assign pc_if       = pc_q;
  assign instr_if    = imem_rdata;
  assign instr_id    = instr_id_q;
  assign pc_plus4_id = pc_plus4_id_q;
  assign valid_id    = valid_id_q;
  assign fetch_count = fetch_count_q;

endmodule

// File: tb/tb_if_stage_fetch.sv
// Bench for if_stage_fetch: directed scenarios with literal expectations, then
// randomized control inputs, all checked every cycle against a behavioural model.
module tb_if_stage_fetch;

  logic        clk = 1'b0;
  logic        rst, stall, flush, branch_taken, jump;
  logic [31:0] branch_target, jump_target;
  logic [31:0] imem_addr, imem_rdata, pc_if, instr_if, pc_plus4_id, instr_id, fetch_count;
  logic        valid_id;

  int checks = 0;
  int errors = 0;
  bit chk_en = 0;

  // Behavioural model state
  logic [31:0] m_pc, m_instr, m_pp4, m_cnt;
  logic        m_valid;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'h1000_0000 + {2'b00, a[31:2]};
  endfunction

  assign imem_rdata = mem_word(imem_addr);

  if_stage_fetch #(.RESET_PC(32'h0), .NOP_INSTR(32'h0)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .jump(jump), .jump_target(jump_target),
    .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .pc_if(pc_if), .instr_if(instr_if),
    .pc_plus4_id(pc_plus4_id), .instr_id(instr_id),
    .valid_id(valid_id), .fetch_count(fetch_count)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model update at each rising edge, using the inputs the DUT samples there.
  task automatic model_edge();
    logic [31:0] npc;
    if (!rst) begin
      m_pc = 32'h0; m_instr = 32'h0; m_pp4 = 32'h0; m_valid = 1'b0; m_cnt = 32'h0;
    end else begin
      if (branch_taken)  npc = branch_target & 32'hFFFF_FFFC;
      else if (jump)     npc = jump_target & 32'hFFFF_FFFC;
      else if (stall)    npc = m_pc;
      else               npc = m_pc + 32'd4;
      if (flush || branch_taken) begin
        m_instr = 32'h0; m_pp4 = 32'h0; m_valid = 1'b0;
      end else if (!stall) begin
        m_instr = mem_word(m_pc); m_pp4 = m_pc + 32'd4; m_valid = 1'b1; m_cnt = m_cnt + 32'd1;
      end
      m_pc = npc;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  // Single compare process: every cycle, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("model pc_if", pc_if, m_pc);
      chk("model imem_addr", imem_addr, m_pc);
      chk("model instr_if", instr_if, mem_word(m_pc));
      chk("model instr_id", instr_id, m_instr);
      chk("model pc_plus4_id", pc_plus4_id, m_pp4);
      chk("model valid_id", {31'd0, valid_id}, {31'd0, m_valid});
      chk("model fetch_count", fetch_count, m_cnt);
    end
  end

  task automatic set_ctl(input logic s, input logic f, input logic b, input logic [31:0] bt,
                         input logic j, input logic [31:0] jt);
    stall = s; flush = f; branch_taken = b; branch_target = bt; jump = j; jump_target = jt;
  endtask

  logic [31:0] saved_cnt;

  initial begin
    rst = 1'b0;
    set_ctl(0, 0, 0, 32'h0, 0, 32'h0);
    @(negedge clk);
    step();
    chk_en = 1;
    step();
    rst = 1'b1;

    // Reset then run
    chk("reset pc_if", pc_if, 32'h0);
    chk("reset instr_if", instr_if, 32'h1000_0000);
    chk("reset valid_id", {31'd0, valid_id}, 32'd0);
    chk("reset fetch_count", fetch_count, 32'd0);
    chk("reset instr_id", instr_id, 32'h0);
    step();
    chk("run instr_id", instr_id, 32'h1000_0000);
    chk("run pc_plus4_id", pc_plus4_id, 32'd4);
    chk("run valid_id", {31'd0, valid_id}, 32'd1);
    repeat (3) step();
    chk("run4 pc_if", pc_if, 32'h10);
    chk("run4 fetch_count", fetch_count, 32'd4);

    // Stall at PC=0x8 with IF/ID holding the word from 0x4
    set_ctl(0, 0, 1, 32'h4, 0, 32'h0);
    step();
    set_ctl(0, 0, 0, 32'h0, 0, 32'h0);
    step();
    saved_cnt = fetch_count;
    chk("pre-stall pc_if", pc_if, 32'h8);
    stall = 1'b1;
    repeat (2) begin
      step();
      chk("stall pc_if", pc_if, 32'h8);
      chk("stall instr_id", instr_id, 32'h1000_0001);
      chk("stall pc_plus4_id", pc_plus4_id, 32'h8);
      chk("stall fetch_count", fetch_count, saved_cnt);
    end
    stall = 1'b0;
    step();
    chk("unstall pc_if", pc_if, 32'hC);
    chk("unstall instr_id", instr_id, 32'h1000_0002);

    // Branch during stall
    step();
    step();
    chk("pre-branch pc_if", pc_if, 32'h14);
    set_ctl(1, 0, 1, 32'h41, 0, 32'h0);
    step();
    chk("brstall pc_if", pc_if, 32'h40);
    chk("brstall valid_id", {31'd0, valid_id}, 32'd0);
    chk("brstall instr_id", instr_id, 32'h0);
    set_ctl(0, 0, 0, 32'h0, 0, 32'h0);
    step();
    chk("postbr instr_id", instr_id, 32'h1000_0010);

    // Jump without and with flush (PC=0x44 here)
    set_ctl(0, 0, 0, 32'h0, 1, 32'h100);
    step();
    chk("jump pc_if", pc_if, 32'h100);
    chk("jump valid_id", {31'd0, valid_id}, 32'd1);
    chk("jump instr_id", instr_id, 32'h1000_0011);
    set_ctl(0, 1, 0, 32'h0, 1, 32'h100);
    step();
    chk("jumpfl pc_if", pc_if, 32'h100);
    chk("jumpfl valid_id", {31'd0, valid_id}, 32'd0);

    // Simultaneous branch and jump
    set_ctl(0, 0, 1, 32'h200, 1, 32'h300);
    step();
    chk("brjmp pc_if", pc_if, 32'h200);
    chk("brjmp valid_id", {31'd0, valid_id}, 32'd0);
    chk("brjmp instr_id", instr_id, 32'h0);

    // PC wrap
    set_ctl(0, 0, 1, 32'hFFFF_FFFE, 0, 32'h0);
    step();
    chk("wrap pre pc_if", pc_if, 32'hFFFF_FFFC);
    set_ctl(0, 0, 0, 32'h0, 0, 32'h0);
    step();
    chk("wrap pc_if", pc_if, 32'h0);
    chk("wrap pc_plus4_id", pc_plus4_id, 32'h0);
    chk("wrap valid_id", {31'd0, valid_id}, 32'd1);

    // Reset mid-run overrides stall and branch
    step();
    rst = 1'b0;
    set_ctl(1, 0, 1, 32'h500, 0, 32'h0);
    step();
    chk("midrst pc_if", pc_if, 32'h0);
    chk("midrst valid_id", {31'd0, valid_id}, 32'd0);
    chk("midrst fetch_count", fetch_count, 32'd0);
    rst = 1'b1;
    set_ctl(0, 0, 0, 32'h0, 0, 32'h0);

    // Randomized control inputs
    for (int i = 0; i < 400; i++) begin
      rst           = ($urandom_range(0, 49) != 0);
      stall         = ($urandom_range(0, 3) == 0);
      flush         = ($urandom_range(0, 7) == 0);
      branch_taken  = ($urandom_range(0, 7) == 0);
      jump          = ($urandom_range(0, 7) == 0);
      branch_target = $urandom();
      jump_target   = $urandom();
      step();
    end

    chk_en = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
